// File: rtl/ripple_cap_pkg.sv
// Shared types and helpers for the ripple counter capture block.
package ripple_cap_pkg;

    // Capture sequencer states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILTER = 2'd1,
        HOLD   = 2'd2
    } state_e;

    // Depth of the per-bit synchronizer in front of the filter
    localparam int SYNC_STAGES = 2;

    // Elapsed-count result: wrap flag plus a 32-bit container for the delta
    typedef struct packed {
        logic        wrap;
        logic [31:0] delta;
    } delta_wrap_t;

    // Down-counter elapsed count from prev to cur, modulo 2^width.
    // wrap is set when cur is above prev, i.e. the counter passed through 0.
    function automatic delta_wrap_t calc_delta_wrap(input logic [31:0] prev,
                                                    input logic [31:0] cur,
                                                    input int unsigned width);
        delta_wrap_t r;
        logic [31:0] mask;
        mask    = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
        r.delta = (prev - cur) & mask;
        r.wrap  = (cur > prev);
        return r;
    endfunction

endpackage

// File: rtl/ripple_count_capture_sync_vec.sv
// W-bit multi-flop synchronizer for a vector that is asynchronous to clk.
// Bits are synchronized independently; coherence is restored by the
// stability filter downstream.
module sync_vec
    import ripple_cap_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] stage_q [SYNC_STAGES];
    logic [W-1:0] stage_d [SYNC_STAGES];

    // Shift the input one stage down the chain each clock
    always_comb begin
        stage_d[0] = din;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // Synchronizer flops
    // NOTE: this is a short flop chain, not a RAM, so every stage takes the reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign dout = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/ripple_count_capture.sv
// Samples a free-running async ripple down-counter, waits for the synced
// value to settle, and on request hands a stable capture plus the elapsed
// count since the previous good capture to the next stage (valid/ready).
module ripple_count_capture
    import ripple_cap_pkg::*;
#(
    parameter int N       = 4,
    parameter int STABLE  = 3,
    parameter int TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] cnt_in,
    input  logic         cap_req,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [N-1:0] cap_value,
    output logic [N-1:0] cap_delta,
    output logic         cap_wrap,
    output logic         cap_timeout,
    output logic         busy
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] STAB_HIT = CW'(STABLE - 2);
    localparam logic [CW-1:0] TO_HIT   = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    state_e       state_q, state_d;
    logic [N-1:0] sync_now;
    logic [N-1:0] sync_prev_q, sync_prev_d;
    logic [CW-1:0] stab_cnt_q, stab_cnt_d;
    logic [CW-1:0] to_cnt_q, to_cnt_d;
    logic [N-1:0] prev_capture_q, prev_capture_d;
    logic [N-1:0] cap_value_q, cap_value_d;
    logic [N-1:0] cap_delta_q, cap_delta_d;
    logic         cap_wrap_q, cap_wrap_d;
    logic         cap_timeout_q, cap_timeout_d;

    logic         same;
    delta_wrap_t  dw;
    logic         unused_delta_hi;

    sync_vec #(.W(N)) u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (cnt_in),
        .dout (sync_now)
    );

    // Delta/wrap against the pre-update previous capture
    assign dw = calc_delta_wrap(32'(prev_capture_q), 32'(sync_now), N);
    // Upper bits of the 32-bit helper result are zero whenever N < 32
    assign unused_delta_hi = ^dw.delta;
    assign same = (sync_now == sync_prev_q);

    // Next-state, filter counters and result latching
    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d        = state_q;
        sync_prev_d    = sync_now;
        stab_cnt_d     = stab_cnt_q;
        to_cnt_d       = to_cnt_q;
        prev_capture_d = prev_capture_q;
        cap_value_d    = cap_value_q;
        cap_delta_d    = cap_delta_q;
        cap_wrap_d     = cap_wrap_q;
        cap_timeout_d  = cap_timeout_q;

        case (state_q)
            IDLE: begin
                if (cap_req) begin
                    state_d    = FILTER;
                    stab_cnt_d = '0;
                    to_cnt_d   = '0;
                end
            end
            FILTER: begin
                if (same && (stab_cnt_q == STAB_HIT)) begin
                    // Stable capture: becomes the new reference point
                    state_d        = HOLD;
                    cap_value_d    = sync_now;
                    cap_delta_d    = dw.delta[N-1:0];
                    cap_wrap_d     = dw.wrap;
                    cap_timeout_d  = 1'b0;
                    prev_capture_d = sync_now;
                end else if (to_cnt_q == TO_HIT) begin
                    // Forced capture: value may be mid-ripple, so keep the old reference
                    state_d       = HOLD;
                    cap_value_d   = sync_now;
                    cap_delta_d   = dw.delta[N-1:0];
                    cap_wrap_d    = dw.wrap;
                    cap_timeout_d = 1'b1;
                end else begin
                    if (same) begin
                        stab_cnt_d = (stab_cnt_q == CNT_MAX) ? stab_cnt_q : stab_cnt_q + 1'b1;
                    end else begin
                        stab_cnt_d = '0;
                    end
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, filter and result registers
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            sync_prev_q    <= '0;
            stab_cnt_q     <= '0;
            to_cnt_q       <= '0;
            prev_capture_q <= '0;
            cap_value_q    <= '0;
            cap_delta_q    <= '0;
            cap_wrap_q     <= 1'b0;
            cap_timeout_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            sync_prev_q    <= sync_prev_d;
            stab_cnt_q     <= stab_cnt_d;
            to_cnt_q       <= to_cnt_d;
            prev_capture_q <= prev_capture_d;
            cap_value_q    <= cap_value_d;
            cap_delta_q    <= cap_delta_d;
            cap_wrap_q     <= cap_wrap_d;
            cap_timeout_q  <= cap_timeout_d;
        end
    end

    assign out_valid   = (state_q == HOLD);
    assign busy        = (state_q != IDLE);
    assign cap_value   = cap_value_q;
    assign cap_delta   = cap_delta_q;
    assign cap_wrap    = cap_wrap_q;
    assign cap_timeout = cap_timeout_q;

endmodule

// File: tb/tb_ripple_count_capture.sv
// Bench for ripple_count_capture: directed stimulus, a cycle model of the
// capture rules checked every negedge, and literal expectations per scenario.
module tb_ripple_count_capture;

    localparam int N       = 4;
    localparam int STABLE  = 3;
    localparam int TIMEOUT = 16;
    localparam int MASK    = (1 << N) - 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] cnt_in = '0;
    logic         cap_req = 1'b0;
    logic         out_ready = 1'b1;
    logic         out_valid;
    logic [N-1:0] cap_value;
    logic [N-1:0] cap_delta;
    logic         cap_wrap;
    logic         cap_timeout;
    logic         busy;

    ripple_count_capture #(.N(N), .STABLE(STABLE), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .cnt_in      (cnt_in),
        .cap_req     (cap_req),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .cap_value   (cap_value),
        .cap_delta   (cap_delta),
        .cap_wrap    (cap_wrap),
        .cap_timeout (cap_timeout),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // samp[0] = cnt_in taken at the latest edge, samp[1] = synced value now,
    // samp[2] = synced value one cycle earlier.
    int samp [3];
    int phase;          // 0 idle, 1 settling, 2 result offered
    int streak;         // consecutive equal synced pairs seen, beyond the first
    int spent;          // cycles spent settling
    int ref_val;        // last good capture
    int m_val, m_delta, m_wrap, m_tmo;

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) samp[i] = 0;
        phase = 0; streak = 0; spent = 0; ref_val = 0;
        m_val = 0; m_delta = 0; m_wrap = 0; m_tmo = 0;
    endfunction

    function automatic void model_take(input int v, input int forced);
        m_val   = v;
        m_delta = (ref_val - v) & MASK;
        m_wrap  = (v > ref_val) ? 1 : 0;
        m_tmo   = forced;
        if (forced == 0) ref_val = v;
        phase = 2;
    endfunction

    // Effect of the coming clock edge given the inputs presented now
    function automatic void model_advance();
        int now_v;
        int old_v;
        now_v = samp[1];
        old_v = samp[2];
        if (phase == 0) begin
            if (cap_req) begin
                phase = 1; streak = 0; spent = 0;
            end
        end else if (phase == 1) begin
            if (now_v == old_v && streak + 2 == STABLE) model_take(now_v, 0);
            else if (spent == TIMEOUT - 1) model_take(now_v, 1);
            else begin
                streak = (now_v == old_v) ? streak + 1 : 0;
                spent++;
            end
        end else begin
            if (out_ready) phase = 0;
        end
        samp[2] = samp[1];
        samp[1] = samp[0];
        samp[0] = int'(cnt_in);
    endfunction

    initial model_reset();

    // Compare DUT against the model every cycle, away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            if (rst) model_reset();
            check("cycle{valid,busy,tmo,wrap,delta,value}",
                  {20'd0, out_valid, busy, cap_timeout, cap_wrap, cap_delta, cap_value},
                  {20'd0, phase == 2, phase != 0, m_tmo != 0, m_wrap != 0, 4'(m_delta), 4'(m_val)});
            if (!rst) model_advance();
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse cap_req for one edge, then wait (bounded) for out_valid.
    // lat counts edges after the request edge.
    task automatic capture(input int budget, output int lat);
        cap_req = 1'b1;
        step();
        cap_req = 1'b0;
        lat = 0;
        while (!out_valid && lat < budget) begin
            step();
            lat++;
        end
    endtask

    int lat;

    initial begin
        // 1: reset with a moving input
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cnt_in = 4'($urandom);
            step();
        end
        check("reset_outputs", {out_valid, busy, cap_timeout, cap_wrap, cap_delta, cap_value}, 0);
        rst = 1'b0;
        repeat (3) step();
        check("idle_after_reset", busy, 0);

        // 2: static A, first capture against reference 0
        cnt_in = 4'hA;
        out_ready = 1'b1;
        repeat (4) step();
        capture(20, lat);
        check("t2_valid", out_valid, 1);
        check("t2_latency_within_4", lat <= STABLE + 1, 1);
        check("t2_value", cap_value, 4'hA);
        check("t2_delta", cap_delta, 4'h6);
        check("t2_wrap", cap_wrap, 1);
        check("t2_timeout", cap_timeout, 0);
        step();
        check("t2_back_to_idle", busy, 0);

        // 3: static 3, delta from A
        cnt_in = 4'h3;
        repeat (4) step();
        out_ready = 1'b0;
        capture(20, lat);
        check("t3_valid", out_valid, 1);
        check("t3_value", cap_value, 4'h3);
        check("t3_delta", cap_delta, 4'h7);
        check("t3_wrap", cap_wrap, 0);

        // 4: backpressure in HOLD, stray request ignored
        for (int i = 0; i < 5; i++) begin
            cap_req = (i == 1);
            step();
            check("t4_frozen", {out_valid, cap_wrap, cap_delta, cap_value}, {1'b1, 1'b0, 4'h7, 4'h3});
        end
        cap_req = 1'b0;
        out_ready = 1'b1;
        step();
        check("t4_idle_after_ready", {out_valid, busy}, 0);
        step();
        check("t4_request_not_queued", busy, 0);

        // 5: toggling input forces a timeout capture
        out_ready = 1'b0;
        cap_req = 1'b1;
        cnt_in = 4'h5;
        step();
        cap_req = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            cnt_in = (cnt_in == 4'h5) ? 4'hA : 4'h5;
            step();
            lat++;
        end
        check("t5_valid", out_valid, 1);
        check("t5_forced_latency", lat, TIMEOUT);
        check("t5_timeout_flag", cap_timeout, 1);
        out_ready = 1'b1;
        cnt_in = 4'h1;
        step();

        // 5b: next good capture measured from 3, not from the forced value
        repeat (4) step();
        capture(20, lat);
        check("t5b_value", cap_value, 4'h1);
        check("t5b_delta", cap_delta, 4'h2);
        check("t5b_wrap", cap_wrap, 0);
        check("t5b_timeout", cap_timeout, 0);
        step();

        // 6: reset in the middle of filtering
        cnt_in = 4'h7;
        repeat (4) step();
        cap_req = 1'b1;
        step();
        cap_req = 1'b0;
        step();
        check("t6_in_filter", busy, 1);
        rst = 1'b1;
        #1;
        check("t6_reset_immediate", {out_valid, busy, cap_value}, 0);
        step();
        step();
        rst = 1'b0;
        cnt_in = 4'hF;
        repeat (4) step();
        capture(20, lat);
        check("t6_value", cap_value, 4'hF);
        check("t6_delta_from_zero", cap_delta, 4'h1);
        check("t6_wrap", cap_wrap, 1);
        repeat (2) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
